// File: rtl/pcs_pkg.sv
// Shared definitions for the 1000BASE-X PCS synchronization state machine.
package pcs_pkg;

  localparam int unsigned STATE_W          = 4;
  localparam int unsigned GOOD_CGS_MAX_DEF = 3;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;
  localparam logic [7:0] K28_5     = 8'hBC;

  typedef enum logic [STATE_W-1:0] {
    ST_LOSS_OF_SYNC = 4'd0,
    ST_COMMA_DET_1  = 4'd1,
    ST_COMMA_DET_2  = 4'd2,
    ST_COMMA_DET_3  = 4'd3,
    ST_ACQ_SYNC_1   = 4'd4,
    ST_ACQ_SYNC_2   = 4'd5,
    ST_SYNC_ACQ_1   = 4'd6,
    ST_SYNC_ACQ_2   = 4'd7,
    ST_SYNC_ACQ_2A  = 4'd8,
    ST_SYNC_ACQ_3   = 4'd9,
    ST_SYNC_ACQ_3A  = 4'd10,
    ST_SYNC_ACQ_4   = 4'd11,
    ST_SYNC_ACQ_4A  = 4'd12
  } pcs_state_e;

  // Comma detection looks only at the first seven bits (a..g) of the group.
  function automatic logic is_comma(input logic [6:0] cg_hi);
    return (cg_hi == COMMA_POS) || (cg_hi == COMMA_NEG);
  endfunction

  function automatic logic in_sync_acquired(input pcs_state_e st);
    return st inside {ST_SYNC_ACQ_1, ST_SYNC_ACQ_2, ST_SYNC_ACQ_2A, ST_SYNC_ACQ_3,
                      ST_SYNC_ACQ_3A, ST_SYNC_ACQ_4, ST_SYNC_ACQ_4A};
  endfunction

endpackage

// File: rtl/pcs_sync.sv
// 1000BASE-X PCS code-group synchronization (comma acquisition / loss-of-sync).
// Define PCS_SYNC_STATS_EN to build the saturating lost-sync counter on loss_cnt.
module pcs_sync
  import pcs_pkg::*;
#(
  parameter int unsigned GOOD_CGS_MAX = GOOD_CGS_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        signal_detect,
  input  logic [9:0]  rx_code,
  input  logic [7:0]  data_in,
  input  logic        control,
  input  logic        code_valid,
  output logic        sync_status,
  output logic        EVEN,
  output logic [7:0]  data_out,
  output logic        control_out,
  output logic [15:0] loss_cnt
);

  localparam int unsigned GCS_W = (GOOD_CGS_MAX > 0) ? $clog2(GOOD_CGS_MAX + 1) : 1;

  pcs_state_e       state_q, state_d;
  logic             rx_even_q, rx_even_d;
  logic             sync_status_q, sync_status_d;
  logic [GCS_W-1:0] good_cgs_q, good_cgs_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             control_out_q, control_out_d;

  logic cgcomma, cgbad, cggood, cgdata, gcs_max;

  // The low three bits never take part in comma detection.
  logic unused_rx_low;
  assign unused_rx_low = ^rx_code[2:0];

  assign cgcomma = is_comma(rx_code[9:3]);
  assign cgbad   = !code_valid || (cgcomma && rx_even_q);
  assign cggood  = !cgbad;
  assign cgdata  = code_valid && !control;
  assign gcs_max = (good_cgs_q == GCS_W'(GOOD_CGS_MAX));

  // Next state from the current group, then entry actions of the chosen state.
  always_comb begin
    state_d       = state_q;
    rx_even_d     = rx_even_q;
    sync_status_d = sync_status_q;
    good_cgs_d    = good_cgs_q;
    data_out_d    = data_in;
    control_out_d = control;

    case (state_q)
      ST_LOSS_OF_SYNC: state_d = cgcomma ? ST_COMMA_DET_1 : ST_LOSS_OF_SYNC;
      ST_COMMA_DET_1:  state_d = cgdata ? ST_ACQ_SYNC_1 : ST_LOSS_OF_SYNC;
      ST_COMMA_DET_2:  state_d = cgdata ? ST_ACQ_SYNC_2 : ST_LOSS_OF_SYNC;
      ST_COMMA_DET_3:  state_d = cgdata ? ST_SYNC_ACQ_1 : ST_LOSS_OF_SYNC;
      ST_ACQ_SYNC_1: begin
        if (cgbad)                        state_d = ST_LOSS_OF_SYNC;
        else if (cgcomma && !rx_even_q)   state_d = ST_COMMA_DET_2;
      end
      ST_ACQ_SYNC_2: begin
        if (cgbad)                        state_d = ST_LOSS_OF_SYNC;
        else if (cgcomma && !rx_even_q)   state_d = ST_COMMA_DET_3;
      end
      ST_SYNC_ACQ_1:  state_d = cgbad ? ST_SYNC_ACQ_2 : ST_SYNC_ACQ_1;
      ST_SYNC_ACQ_2:  state_d = cgbad ? ST_SYNC_ACQ_3 : ST_SYNC_ACQ_2A;
      ST_SYNC_ACQ_2A: state_d = cgbad ? ST_SYNC_ACQ_3 : (gcs_max ? ST_SYNC_ACQ_1 : ST_SYNC_ACQ_2A);
      ST_SYNC_ACQ_3:  state_d = cgbad ? ST_SYNC_ACQ_4 : ST_SYNC_ACQ_3A;
      ST_SYNC_ACQ_3A: state_d = cgbad ? ST_SYNC_ACQ_4 : (gcs_max ? ST_SYNC_ACQ_2 : ST_SYNC_ACQ_3A);
      ST_SYNC_ACQ_4:  state_d = cgbad ? ST_LOSS_OF_SYNC : ST_SYNC_ACQ_4A;
      ST_SYNC_ACQ_4A: state_d = cgbad ? ST_LOSS_OF_SYNC : (gcs_max ? ST_SYNC_ACQ_3 : ST_SYNC_ACQ_4A);
      default:        state_d = ST_LOSS_OF_SYNC;
    endcase

    if (!signal_detect) state_d = ST_LOSS_OF_SYNC;

    // Every transition, including a self-loop, re-runs the target's entry actions.
    case (state_d)
      ST_LOSS_OF_SYNC: begin
        rx_even_d     = !rx_even_q;
        sync_status_d = 1'b0;
      end
      ST_COMMA_DET_1, ST_COMMA_DET_2, ST_COMMA_DET_3: rx_even_d = 1'b1;
      ST_ACQ_SYNC_1, ST_ACQ_SYNC_2: rx_even_d = !rx_even_q;
      ST_SYNC_ACQ_1: begin
        rx_even_d     = !rx_even_q;
        sync_status_d = 1'b1;
      end
      ST_SYNC_ACQ_2, ST_SYNC_ACQ_3, ST_SYNC_ACQ_4: begin
        rx_even_d  = !rx_even_q;
        good_cgs_d = '0;
      end
      ST_SYNC_ACQ_2A, ST_SYNC_ACQ_3A, ST_SYNC_ACQ_4A: begin
        rx_even_d  = !rx_even_q;
        good_cgs_d = good_cgs_q + GCS_W'(1);
      end
      default: rx_even_d = rx_even_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOSS_OF_SYNC;
      rx_even_q     <= 1'b0;
      sync_status_q <= 1'b0;
      good_cgs_q    <= '0;
      data_out_q    <= '0;
      control_out_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_even_q     <= rx_even_d;
      sync_status_q <= sync_status_d;
      good_cgs_q    <= good_cgs_d;
      data_out_q    <= data_out_d;
      control_out_q <= control_out_d;
    end
  end

  assign sync_status = sync_status_q;
  assign EVEN        = rx_even_q;
  assign data_out    = data_out_q;
  assign control_out = control_out_q;

`ifdef PCS_SYNC_STATS_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;

  // Count every drop out of any SYNC_ACQUIRED state, forced or not; saturates.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (in_sync_acquired(state_q) && (state_d == ST_LOSS_OF_SYNC) && (loss_cnt_q != 16'hFFFF))
      loss_cnt_d = loss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) loss_cnt_q <= '0;
    else       loss_cnt_q <= loss_cnt_d;
  end

  assign loss_cnt = loss_cnt_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pcs_sync.sv
// Scoreboard bench for pcs_sync: stimulus pushes expected outputs, a monitor pops and compares.
module tb_pcs_sync;

  localparam logic [9:0] K_CODE = 10'b0011111010;
  localparam logic [9:0] D_CODE = 10'b1001000101;
`ifdef PCS_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        signal_detect = 1'b0;
  logic [9:0]  rx_code = '0;
  logic [7:0]  data_in = '0;
  logic        control = 1'b0;
  logic        code_valid = 1'b0;
  logic        sync_status, EVEN, control_out;
  logic [7:0]  data_out;
  logic [15:0] loss_cnt;

  pcs_sync dut (
    .clk(clk), .reset(reset), .signal_detect(signal_detect), .rx_code(rx_code),
    .data_in(data_in), .control(control), .code_valid(code_valid),
    .sync_status(sync_status), .EVEN(EVEN), .data_out(data_out),
    .control_out(control_out), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sync;
    logic        even;
    logic [7:0]  data;
    logic        ctl;
    logic [15:0] loss;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_loss = '0;

  // Monitor: one code-group leaves the DUT per cycle.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (sync_status !== e.sync || EVEN !== e.even || data_out !== e.data ||
          control_out !== e.ctl || loss_cnt !== e.loss) begin
        errors++;
        $display("FAIL %s: got sync=%b even=%b data=%h ctl=%b loss=%0d, want sync=%b even=%b data=%h ctl=%b loss=%0d",
                 e.name, sync_status, EVEN, data_out, control_out, loss_cnt,
                 e.sync, e.even, e.data, e.ctl, e.loss);
      end
    end
  end

  task automatic cg(input logic [9:0] code, input logic [7:0] d, input logic c, input logic v,
                    input logic sd, input logic rst, input logic es, input logic ee, input string nm);
    exp_t x;
    @(negedge clk);
    reset = rst; signal_detect = sd; rx_code = code; data_in = d; control = c; code_valid = v;
    if (rst) exp_loss = '0;
    x.sync = es; x.even = ee;
    x.data = rst ? 8'h00 : d;
    x.ctl  = rst ? 1'b0 : c;
    x.loss = exp_loss;
    x.name = nm;
    sb_q.push_back(x);
  endtask

  task automatic k  (input logic es, input logic ee, input string nm); cg(K_CODE, 8'hBC, 1'b1, 1'b1, 1'b1, 1'b0, es, ee, nm); endtask
  task automatic d  (input logic es, input logic ee, input string nm); cg(D_CODE, 8'h50, 1'b0, 1'b1, 1'b1, 1'b0, es, ee, nm); endtask
  task automatic bad(input logic es, input logic ee, input string nm); cg(D_CODE, 8'h50, 1'b0, 1'b0, 1'b1, 1'b0, es, ee, nm); endtask
  task automatic rst_cyc(input string nm); cg(K_CODE, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, nm); endtask
  task automatic lose(); if (STATS) exp_loss = exp_loss + 16'd1; endtask

  initial begin
    rst_cyc("reset");
    // No commas: stays in LOSS_OF_SYNC, parity toggling.
    d(0, 1, "los_toggle1");
    d(0, 0, "los_toggle2");
    // Acquire: three K28.5/D16.2 pairs.
    k(0, 1, "acq_k1"); d(0, 0, "acq_d1");
    k(0, 1, "acq_k2"); d(0, 0, "acq_d2");
    k(0, 1, "acq_k3"); d(1, 0, "acq_d3_sync");
    // Comma in an odd slot -> SA2, then 4 good -> SA1.
    d(1, 1, "odd_pre");
    k(1, 0, "odd_comma");
    d(1, 1, "odd_g1"); d(1, 0, "odd_g2"); d(1, 1, "odd_g3"); d(1, 0, "odd_g4");
    // Single bad + exactly 4 good -> SA1; second bad -> SA2.
    bad(1, 1, "rec_bad1");
    d(1, 0, "rec_g1"); d(1, 1, "rec_g2"); d(1, 0, "rec_g3"); d(1, 1, "rec_g4");
    bad(1, 0, "rec_bad2");
    // From SA2: three more bads with 3 good between -> loss only at the last.
    d(1, 1, "sa2_g1"); d(1, 0, "sa2_g2"); d(1, 1, "sa2_g3");
    bad(1, 0, "sa3_bad");
    d(1, 1, "sa3_g1"); d(1, 0, "sa3_g2"); d(1, 1, "sa3_g3");
    bad(1, 0, "sa4_bad");
    d(1, 1, "sa4_g1"); d(1, 0, "sa4_g2"); d(1, 1, "sa4_g3");
    lose(); bad(0, 0, "loss_bad");
    // Reacquire, then drop signal_detect for one cycle.
    k(0, 1, "re1_k1"); d(0, 0, "re1_d1");
    k(0, 1, "re1_k2"); d(0, 0, "re1_d2");
    k(0, 1, "re1_k3"); d(1, 0, "re1_d3_sync");
    lose(); cg(D_CODE, 8'h50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "sd_drop");
    k(0, 1, "re2_k1"); d(0, 0, "re2_d1");
    k(0, 1, "re2_k2"); d(0, 0, "re2_d2");
    k(0, 1, "re2_k3"); d(1, 0, "re2_d3_sync");
    // Four bads each separated by two good groups -> loss.
    bad(1, 1, "err_bad1"); d(1, 0, "err_g1a"); d(1, 1, "err_g1b");
    bad(1, 0, "err_bad2"); d(1, 1, "err_g2a"); d(1, 0, "err_g2b");
    bad(1, 1, "err_bad3"); d(1, 0, "err_g3a"); d(1, 1, "err_g3b");
    lose(); bad(0, 0, "err_bad4_loss");
    // Reset during ACQUIRE_SYNC_2 clears all progress.
    k(0, 1, "mr_k1"); d(0, 0, "mr_d1");
    k(0, 1, "mr_k2"); d(0, 0, "mr_d2");
    rst_cyc("mid_reset");
    k(0, 1, "post_k1"); d(0, 0, "post_d1_no_sync");
    k(0, 1, "post_k2"); d(0, 0, "post_d2_no_sync");
    k(0, 1, "post_k3"); d(1, 0, "post_d3_sync");
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
